// File: rtl/tx_frame_scheduler.sv
// rtl/tx_frame_scheduler.sv - TLP/DLLP framing scheduler with IDL fill; SKP insertion under SKP_INSERT_EN
module tx_frame_scheduler #(
  parameter int LANES        = 4,
  parameter int BITS         = 7,
  parameter int MAX_LEN      = 16,
  parameter int SKP_INTERVAL = 64
) (
  input  logic                       CLK,
  input  logic                       RESET,
  input  logic                       TLP_REQ,
  input  logic [BITS:0]              TLP_DATA,
  input  logic                       TLP_LAST,
  input  logic                       TLP_ABORT,
  output logic                       TLP_ACK,
  input  logic                       DLLP_REQ,
  input  logic [BITS:0]              DLLP_DATA,
  input  logic                       DLLP_LAST,
  output logic                       DLLP_ACK,
  output logic [BITS:0]              D,
  output logic                       DK,
  output logic [$clog2(LANES)-1:0]   LANE_IDX,
  output logic                       BUSY,
  output logic                       ERR
);

  localparam int LW = $clog2(LANES);
  localparam int BW = BITS + 1;
  localparam int CW = $clog2(MAX_LEN + 1);

  localparam logic [BITS:0] TOK_STP = BW'(8'hfb);
  localparam logic [BITS:0] TOK_SDP = BW'(8'h5c);
  localparam logic [BITS:0] TOK_END = BW'(8'hfd);
  localparam logic [BITS:0] TOK_EDB = BW'(8'hfe);
  localparam logic [BITS:0] TOK_IDL = BW'(8'h7c);
`ifdef SKP_INSERT_EN
  localparam logic [BITS:0] TOK_COM = BW'(8'hbc);
  localparam logic [BITS:0] TOK_SKP = BW'(8'h1c);
  localparam int SW = (SKP_INTERVAL > 1) ? $clog2(SKP_INTERVAL) : 1;
`endif

  localparam logic [LW-1:0] LAST_SLOT = LW'(LANES - 1);
  localparam logic SRC_TLP  = 1'b0;
  localparam logic SRC_DLLP = 1'b1;

  // Reject configurations the slot counter and skip timer cannot represent
  if (LANES < 2 || MAX_LEN < 1 || SKP_INTERVAL < 2) begin : g_param_check
    $error("tx_frame_scheduler: unsupported parameter set");
  end

  typedef enum logic [1:0] {ST_IDLE, ST_SKPOS, ST_DATA, ST_TERM} state_e;

  state_e          state_q, state_d;
  logic [LW-1:0]   slot_q, slot_d;
  logic            grant_q, grant_d;
  logic            last_grant_q, last_grant_d;
  logic            use_edb_q, use_edb_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [BITS:0]   d_q, byte_d;
  logic            dk_q, dk_d;
  logic [LW-1:0]   lane_q;
  logic            busy_q, busy_d;
  logic            err_q, err_d;
  logic            tlp_ack, dllp_ack;
  logic            pick;
  logic            cur_req, cur_last, cur_abort;
  logic [BITS:0]   cur_data;
`ifdef SKP_INSERT_EN
  logic [SW-1:0]   skp_cnt_q;
  logic            skp_pend_q;
  logic            skp_done;
`endif

  // Requests/acks are gated off while reset is held so a reset mid-packet never consumes a byte
  assign TLP_ACK  = tlp_ack  & ~RESET;
  assign DLLP_ACK = dllp_ack & ~RESET;
  assign D        = d_q;
  assign DK       = dk_q;
  assign LANE_IDX = lane_q;
  assign BUSY     = busy_q;
  assign ERR      = err_q;

  // View of the granted source so the DATA state handles both sources with one path
  always_comb begin
    cur_req   = (grant_q == SRC_TLP) ? TLP_REQ  : DLLP_REQ;
    cur_data  = (grant_q == SRC_TLP) ? TLP_DATA : DLLP_DATA;
    cur_last  = (grant_q == SRC_TLP) ? TLP_LAST : DLLP_LAST;
    cur_abort = (grant_q == SRC_TLP) & TLP_ABORT;
  end

  // Next-state, produced byte and handshake decode
  always_comb begin
    state_d      = state_q;
    slot_d       = (slot_q == LAST_SLOT) ? '0 : slot_q + LW'(1);
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    use_edb_d    = use_edb_q;
    cnt_d        = cnt_q;
    byte_d       = TOK_IDL;
    dk_d         = 1'b1;
    tlp_ack      = 1'b0;
    dllp_ack     = 1'b0;
    err_d        = 1'b0;
    pick         = (TLP_REQ && (!DLLP_REQ || last_grant_q == SRC_DLLP)) ? SRC_TLP : SRC_DLLP;
`ifdef SKP_INSERT_EN
    skp_done     = 1'b0;
`endif
    case (state_q)
      ST_IDLE: begin
`ifdef SKP_INSERT_EN
        if (slot_q == '0 && skp_pend_q) begin
          byte_d  = TOK_COM;
          dk_d    = 1'b0;
          state_d = ST_SKPOS;
        end else
`endif
        if (slot_q == '0 && (TLP_REQ || DLLP_REQ)) begin
          grant_d      = pick;
          last_grant_d = pick;
          cnt_d        = '0;
          byte_d       = (pick == SRC_TLP) ? TOK_STP : TOK_SDP;
          dk_d         = 1'b0;
          state_d      = ST_DATA;
        end
      end
`ifdef SKP_INSERT_EN
      ST_SKPOS: begin
        byte_d = TOK_SKP;
        if (slot_q == LAST_SLOT) begin
          skp_done = 1'b1;
          state_d  = ST_IDLE;
        end
      end
`endif
      ST_DATA: begin
        if (cur_abort) begin
          use_edb_d = 1'b1;
          state_d   = ST_TERM;
        end else if (cur_req) begin
          tlp_ack  = (grant_q == SRC_TLP);
          dllp_ack = (grant_q == SRC_DLLP);
          byte_d   = cur_data;
          cnt_d    = cnt_q + CW'(1);
          if (cur_last) begin
            use_edb_d = 1'b0;
            state_d   = ST_TERM;
          end else if (cnt_q == CW'(MAX_LEN - 1)) begin
            use_edb_d = 1'b1;
            err_d     = 1'b1;
            state_d   = ST_TERM;
          end
        end
      end
      ST_TERM: begin
        if (slot_q == LAST_SLOT) begin
          byte_d  = use_edb_q ? TOK_EDB : TOK_END;
          dk_d    = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Start and end tokens belong to the frame, so busy covers the entering and leaving cycles
    busy_d = (state_q != ST_IDLE) || (state_d != ST_IDLE);
  end

  // State register and registered byte stream toward the striper
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q      <= ST_IDLE;
      slot_q       <= '0;
      grant_q      <= SRC_TLP;
      last_grant_q <= SRC_DLLP;
      use_edb_q    <= 1'b0;
      cnt_q        <= '0;
      d_q          <= TOK_IDL;
      dk_q         <= 1'b1;
      lane_q       <= LAST_SLOT;
      busy_q       <= 1'b0;
      err_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      slot_q       <= slot_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      use_edb_q    <= use_edb_d;
      cnt_q        <= cnt_d;
      d_q          <= byte_d;
      dk_q         <= dk_d;
      lane_q       <= slot_q;
      busy_q       <= busy_d;
      err_q        <= err_d;
    end
  end

`ifdef SKP_INSERT_EN
  // Free-running skip timer; a new expiry wins over a same-cycle service so no request is lost
  always_ff @(posedge CLK) begin
    if (RESET) begin
      skp_cnt_q  <= '0;
      skp_pend_q <= 1'b0;
    end else begin
      if (skp_cnt_q == SW'(SKP_INTERVAL - 1)) begin
        skp_cnt_q  <= '0;
        skp_pend_q <= 1'b1;
      end else begin
        skp_cnt_q <= skp_cnt_q + SW'(1);
        if (skp_done) skp_pend_q <= 1'b0;
      end
    end
  end
`endif

endmodule

// File: tb/tb_tx_frame_scheduler.sv
// tb/tb_tx_frame_scheduler.sv - directed self-checking bench for tx_frame_scheduler
module tb_tx_frame_scheduler;

  logic       CLK = 1'b0;
  logic       RESET;
  logic       TLP_REQ, TLP_LAST, TLP_ABORT, DLLP_REQ, DLLP_LAST;
  logic [7:0] TLP_DATA, DLLP_DATA;
  logic       TLP_ACK, DLLP_ACK, DK, BUSY, ERR;
  logic [7:0] D;
  logic [1:0] LANE_IDX;

  logic [7:0] m_d;
  logic       m_dk, m_busy, m_err, m_tack, m_dack;
  logic [1:0] m_lane;

  int total = 0;
  int bad   = 0;

  logic [7:0] tq[$];
  logic [7:0] dq[$];
  bit         t_last_en, d_last_en;
  int         abort_at, drop_at;

  logic [7:0] s_d   [64];
  logic       s_dk  [64];
  logic       s_busy[64];
  logic       s_err [64];
  logic       s_tack[64];
  logic       s_dack[64];
  logic [1:0] s_lane[64];

  always #5 CLK = ~CLK;

  tx_frame_scheduler #(.LANES(4), .BITS(7), .MAX_LEN(16), .SKP_INTERVAL(1024)) dut (
    .CLK(CLK), .RESET(RESET),
    .TLP_REQ(TLP_REQ), .TLP_DATA(TLP_DATA), .TLP_LAST(TLP_LAST), .TLP_ABORT(TLP_ABORT), .TLP_ACK(TLP_ACK),
    .DLLP_REQ(DLLP_REQ), .DLLP_DATA(DLLP_DATA), .DLLP_LAST(DLLP_LAST), .DLLP_ACK(DLLP_ACK),
    .D(D), .DK(DK), .LANE_IDX(LANE_IDX), .BUSY(BUSY), .ERR(ERR)
  );

`ifdef SKP_INSERT_EN
  logic       sel_skp = 1'b0;
  logic [7:0] D2;
  logic       DK2, BUSY2, ERR2, TACK2, DACK2;
  logic [1:0] LANE2;

  tx_frame_scheduler #(.LANES(4), .BITS(7), .MAX_LEN(16), .SKP_INTERVAL(8)) dut_skp (
    .CLK(CLK), .RESET(RESET),
    .TLP_REQ(TLP_REQ), .TLP_DATA(TLP_DATA), .TLP_LAST(TLP_LAST), .TLP_ABORT(TLP_ABORT), .TLP_ACK(TACK2),
    .DLLP_REQ(DLLP_REQ), .DLLP_DATA(DLLP_DATA), .DLLP_LAST(DLLP_LAST), .DLLP_ACK(DACK2),
    .D(D2), .DK(DK2), .LANE_IDX(LANE2), .BUSY(BUSY2), .ERR(ERR2)
  );

  assign m_d    = sel_skp ? D2    : D;
  assign m_dk   = sel_skp ? DK2   : DK;
  assign m_busy = sel_skp ? BUSY2 : BUSY;
  assign m_err  = sel_skp ? ERR2  : ERR;
  assign m_tack = sel_skp ? TACK2 : TLP_ACK;
  assign m_dack = sel_skp ? DACK2 : DLLP_ACK;
  assign m_lane = sel_skp ? LANE2 : LANE_IDX;
`else
  assign m_d    = D;
  assign m_dk   = DK;
  assign m_busy = BUSY;
  assign m_err  = ERR;
  assign m_tack = TLP_ACK;
  assign m_dack = DLLP_ACK;
  assign m_lane = LANE_IDX;
`endif

  function automatic logic exp_dk(input logic [7:0] b);
    return !(b == 8'hfb || b == 8'h5c || b == 8'hfd || b == 8'hfe || b == 8'hbc);
  endfunction

  task automatic apply();
    TLP_REQ   = (tq.size() > 0);
    TLP_DATA  = (tq.size() > 0) ? tq[0] : 8'h00;
    TLP_LAST  = t_last_en && (tq.size() == 1);
    DLLP_REQ  = (dq.size() > 0);
    DLLP_DATA = (dq.size() > 0) ? dq[0] : 8'h00;
    DLLP_LAST = d_last_en && (dq.size() == 1);
  endtask

  task automatic clear_src();
    tq.delete(); dq.delete();
    TLP_ABORT = 1'b0; t_last_en = 1'b1; d_last_en = 1'b1;
    abort_at = -1; drop_at = -1;
    apply();
  endtask

  task automatic do_reset();
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1 RESET = 1'b0;
  endtask

  // Sample cycle j at its negedge, then advance the source models just after the next edge
  task automatic run(input int n);
    int t_acks = 0;
    for (int j = 0; j <= n; j++) begin
      @(negedge CLK);
      s_d[j] = m_d; s_dk[j] = m_dk; s_busy[j] = m_busy; s_err[j] = m_err;
      s_tack[j] = m_tack; s_dack[j] = m_dack; s_lane[j] = m_lane;
      if (j == n) break;
      @(posedge CLK); #1;
      if (TLP_ABORT) begin TLP_ABORT = 1'b0; tq.delete(); end
      if (s_tack[j] && tq.size() > 0) begin
        void'(tq.pop_front());
        t_acks++;
        if (t_acks == abort_at) TLP_ABORT = 1'b1;
      end
      if (s_dack[j] && dq.size() > 0) void'(dq.pop_front());
      if (j == drop_at) begin tq.delete(); dq.delete(); end
      apply();
    end
  endtask

  task automatic test_reset();
    clear_src();
    RESET = 1'b1;
    @(posedge CLK); @(negedge CLK);
    total++; if (D !== 8'h7c)      begin bad++; $display("FAIL rst_d got=%h want=7c", D); end
    total++; if (DK !== 1'b1)      begin bad++; $display("FAIL rst_dk got=%b want=1", DK); end
    total++; if (LANE_IDX !== 2'd3) begin bad++; $display("FAIL rst_lane got=%0d want=3", LANE_IDX); end
    total++; if (BUSY !== 1'b0)    begin bad++; $display("FAIL rst_busy got=%b want=0", BUSY); end
    total++; if (ERR !== 1'b0)     begin bad++; $display("FAIL rst_err got=%b want=0", ERR); end
    total++; if (TLP_ACK !== 1'b0) begin bad++; $display("FAIL rst_tack got=%b want=0", TLP_ACK); end
    total++; if (DLLP_ACK !== 1'b0) begin bad++; $display("FAIL rst_dack got=%b want=0", DLLP_ACK); end
    @(posedge CLK); #1 RESET = 1'b0;
    run(8);
    for (int j = 0; j < 8; j++) begin
      total++; if (s_d[j+1] !== 8'h7c) begin bad++; $display("FAIL idle_d j=%0d got=%h want=7c", j, s_d[j+1]); end
      total++; if (s_dk[j+1] !== 1'b1) begin bad++; $display("FAIL idle_dk j=%0d got=%b want=1", j, s_dk[j+1]); end
      total++; if (s_lane[j+1] !== 2'(j % 4)) begin bad++; $display("FAIL idle_lane j=%0d got=%0d want=%0d", j, s_lane[j+1], j % 4); end
      total++; if (s_tack[j] !== 1'b0 || s_dack[j] !== 1'b0) begin bad++; $display("FAIL idle_ack j=%0d got=%b%b want=00", j, s_tack[j], s_dack[j]); end
    end
  endtask

  task automatic test_tlp_two();
    logic [7:0] ed[6] = '{8'hfb, 8'haa, 8'hbb, 8'hfd, 8'h7c, 8'h7c};
    logic       ea[6] = '{0, 1, 1, 0, 0, 0};
    logic       eb[6] = '{1, 1, 1, 1, 0, 0};
    clear_src(); do_reset();
    tq = '{8'haa, 8'hbb}; apply();
    run(6);
    for (int j = 0; j < 6; j++) begin
      total++; if (s_d[j+1] !== ed[j]) begin bad++; $display("FAIL tlp2_d j=%0d got=%h want=%h", j, s_d[j+1], ed[j]); end
      total++; if (s_dk[j+1] !== exp_dk(ed[j])) begin bad++; $display("FAIL tlp2_dk j=%0d got=%b want=%b", j, s_dk[j+1], exp_dk(ed[j])); end
      total++; if (s_lane[j+1] !== 2'(j % 4)) begin bad++; $display("FAIL tlp2_lane j=%0d got=%0d want=%0d", j, s_lane[j+1], j % 4); end
      total++; if (s_tack[j] !== ea[j]) begin bad++; $display("FAIL tlp2_ack j=%0d got=%b want=%b", j, s_tack[j], ea[j]); end
      total++; if (s_busy[j+1] !== eb[j]) begin bad++; $display("FAIL tlp2_busy j=%0d got=%b want=%b", j, s_busy[j+1], eb[j]); end
    end
  endtask

  task automatic test_tlp_three();
    logic [7:0] ed[9] = '{8'hfb, 8'h11, 8'h22, 8'h33, 8'h7c, 8'h7c, 8'h7c, 8'hfd, 8'h7c};
    logic       ea[9] = '{0, 1, 1, 1, 0, 0, 0, 0, 0};
    clear_src(); do_reset();
    tq = '{8'h11, 8'h22, 8'h33}; apply();
    run(9);
    for (int j = 0; j < 9; j++) begin
      total++; if (s_d[j+1] !== ed[j]) begin bad++; $display("FAIL tlp3_d j=%0d got=%h want=%h", j, s_d[j+1], ed[j]); end
      total++; if (s_dk[j+1] !== exp_dk(ed[j])) begin bad++; $display("FAIL tlp3_dk j=%0d got=%b want=%b", j, s_dk[j+1], exp_dk(ed[j])); end
      total++; if (s_tack[j] !== ea[j]) begin bad++; $display("FAIL tlp3_ack j=%0d got=%b want=%b", j, s_tack[j], ea[j]); end
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0] ed[10] = '{8'hfb, 8'h5a, 8'h7c, 8'hfd, 8'h5c, 8'ha5, 8'h7c, 8'hfd, 8'h7c, 8'h7c};
    logic       et[10] = '{0, 1, 0, 0, 0, 0, 0, 0, 0, 0};
    logic       ex[10] = '{0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic       eb[10] = '{1, 1, 1, 1, 1, 1, 1, 1, 0, 0};
    clear_src();
    tq = '{8'h5a}; dq = '{8'ha5}; apply();
    do_reset();
    run(10);
    for (int j = 0; j < 10; j++) begin
      total++; if (s_d[j+1] !== ed[j]) begin bad++; $display("FAIL b2b_d j=%0d got=%h want=%h", j, s_d[j+1], ed[j]); end
      total++; if (s_lane[j+1] !== 2'(j % 4)) begin bad++; $display("FAIL b2b_lane j=%0d got=%0d want=%0d", j, s_lane[j+1], j % 4); end
      total++; if (s_tack[j] !== et[j]) begin bad++; $display("FAIL b2b_tack j=%0d got=%b want=%b", j, s_tack[j], et[j]); end
      total++; if (s_dack[j] !== ex[j]) begin bad++; $display("FAIL b2b_dack j=%0d got=%b want=%b", j, s_dack[j], ex[j]); end
      total++; if (s_busy[j+1] !== eb[j]) begin bad++; $display("FAIL b2b_busy j=%0d got=%b want=%b", j, s_busy[j+1], eb[j]); end
    end
  endtask

  task automatic test_abort();
    logic [7:0] ed[6] = '{8'hfb, 8'h31, 8'h7c, 8'hfe, 8'h7c, 8'h7c};
    logic       ea[6] = '{0, 1, 0, 0, 0, 0};
    clear_src(); do_reset();
    t_last_en = 1'b0; abort_at = 1;
    tq = '{8'h31, 8'h32}; apply();
    run(6);
    for (int j = 0; j < 6; j++) begin
      total++; if (s_d[j+1] !== ed[j]) begin bad++; $display("FAIL abort_d j=%0d got=%h want=%h", j, s_d[j+1], ed[j]); end
      total++; if (s_dk[j+1] !== exp_dk(ed[j])) begin bad++; $display("FAIL abort_dk j=%0d got=%b want=%b", j, s_dk[j+1], exp_dk(ed[j])); end
      total++; if (s_tack[j] !== ea[j]) begin bad++; $display("FAIL abort_ack j=%0d got=%b want=%b", j, s_tack[j], ea[j]); end
      total++; if (s_err[j+1] !== 1'b0) begin bad++; $display("FAIL abort_err j=%0d got=%b want=0", j, s_err[j+1]); end
    end
  endtask

  task automatic test_overrun();
    logic [7:0] ed;
    logic       ea, ee;
    int         acks = 0;
    clear_src(); do_reset();
    t_last_en = 1'b0; drop_at = 19;
    for (int i = 0; i < 17; i++) tq.push_back(8'h40 + 8'(i));
    apply();
    run(22);
    for (int j = 0; j < 22; j++) begin
      ed = (j == 0) ? 8'hfb : (j <= 16) ? 8'h40 + 8'(j - 1) : (j == 19) ? 8'hfe : 8'h7c;
      ea = (j >= 1 && j <= 16);
      ee = (j == 16);
      if (s_tack[j] === 1'b1) acks++;
      total++; if (s_d[j+1] !== ed) begin bad++; $display("FAIL ovr_d j=%0d got=%h want=%h", j, s_d[j+1], ed); end
      total++; if (s_tack[j] !== ea) begin bad++; $display("FAIL ovr_ack j=%0d got=%b want=%b", j, s_tack[j], ea); end
      total++; if (s_err[j+1] !== ee) begin bad++; $display("FAIL ovr_err j=%0d got=%b want=%b", j, s_err[j+1], ee); end
      total++; if (s_busy[j+1] !== (j <= 19)) begin bad++; $display("FAIL ovr_busy j=%0d got=%b want=%b", j, s_busy[j+1], j <= 19); end
    end
    total++; if (acks != 16) begin bad++; $display("FAIL ovr_ack_count got=%0d want=16", acks); end
  endtask

`ifdef SKP_INSERT_EN
  task automatic test_skp();
    logic [7:0] ed;
    logic [7:0] e2[12] = '{8'h7c, 8'h7c, 8'hbc, 8'h1c, 8'h1c, 8'h1c, 8'hfb, 8'h77, 8'h7c, 8'hfd, 8'hbc, 8'h1c};
    logic       ea[12] = '{0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0};
    logic       eb[12] = '{0, 0, 1, 1, 1, 1, 1, 1, 1, 1, 1, 1};
    sel_skp = 1'b1;
    clear_src(); do_reset();
    run(21);
    for (int j = 0; j < 21; j++) begin
      ed = (j == 8 || j == 16) ? 8'hbc : ((j >= 9 && j <= 11) || (j >= 17 && j <= 19)) ? 8'h1c : 8'h7c;
      total++; if (s_d[j+1] !== ed) begin bad++; $display("FAIL skp_d j=%0d got=%h want=%h", j, s_d[j+1], ed); end
      total++; if (s_dk[j+1] !== exp_dk(ed)) begin bad++; $display("FAIL skp_dk j=%0d got=%b want=%b", j, s_dk[j+1], exp_dk(ed)); end
      total++; if (s_lane[j+1] !== 2'(j % 4)) begin bad++; $display("FAIL skp_lane j=%0d got=%0d want=%0d", j, s_lane[j+1], j % 4); end
    end
    @(posedge CLK); #1;
    tq = '{8'h77}; apply();
    run(12);
    for (int k = 0; k < 12; k++) begin
      total++; if (s_d[k+1] !== e2[k]) begin bad++; $display("FAIL skp_tlp_d c=%0d got=%h want=%h", 22 + k, s_d[k+1], e2[k]); end
      total++; if (s_lane[k+1] !== 2'((22 + k) % 4)) begin bad++; $display("FAIL skp_tlp_lane c=%0d got=%0d want=%0d", 22 + k, s_lane[k+1], (22 + k) % 4); end
      total++; if (s_tack[k] !== ea[k]) begin bad++; $display("FAIL skp_tlp_ack c=%0d got=%b want=%b", 22 + k, s_tack[k], ea[k]); end
      total++; if (s_busy[k+1] !== eb[k]) begin bad++; $display("FAIL skp_tlp_busy c=%0d got=%b want=%b", 22 + k, s_busy[k+1], eb[k]); end
    end
    sel_skp = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_tlp_two();
    test_tlp_three();
    test_back_to_back();
    test_abort();
    test_overrun();
`ifdef SKP_INSERT_EN
    test_skp();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

endmodule
